// File: rtl/scu_irq_ctrl_if.sv
// Bus between the SCU interrupt controller and its host: request pulses,
// register port, and the CPU level/vector/acknowledge handshake.
interface scu_irq_ctrl_if #(
   parameter int NSRC = 32
);
   logic             ce;
   logic [NSRC-1:0]  irq;
   logic [1:0]       reg_sel;
   logic             reg_wr;
   logic [31:0]      reg_di;
   logic [31:0]      reg_do;
   logic [3:0]       irl;
   logic [7:0]       vec;
   logic             iack;

   // Host / CPU side: drives requests, register accesses and acknowledges.
   modport master (
      output ce, irq, reg_sel, reg_wr, reg_di, iack,
      input  reg_do, irl, vec
   );

   // Controller side.
   modport slave (
      input  ce, irq, reg_sel, reg_wr, reg_di, iack,
      output reg_do, irl, vec
   );
endinterface

// File: rtl/scu_irq_ctrl.sv
// SCU interrupt controller: latches request pulses into a status register,
// masks them, arbitrates the highest-level candidate and presents it to the
// SH-2 as IRL/VEC until acknowledged. External (A-bus) sources are locked out
// while busy is set, and busy is released by an AIACK register write.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing presented, IRL = 0; loads the winner when one exists
// PRESENT  | IRL/VEC driven, re-arbitrated every CE cycle, waits for IACK
// ACKED    | one CE cycle with IRL = 0 after an acknowledge
module scu_irq_ctrl #(
   parameter int                NSRC      = 32,
   parameter logic [31:0]       EXT_MASK  = 32'hFFFF0000,
   parameter logic [4*NSRC-1:0] LVL_TABLE = 128'h11111111_44447777_00255668_89ABCDEF,
   parameter logic [7:0]        VEC_BASE  = 8'h40,
   parameter logic [31:0]       MASK_INIT = 32'h0000BFFF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   scu_irq_ctrl_if.slave     bus
);

   localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam logic [NSRC-1:0] EXT_SRC  = EXT_MASK[NSRC-1:0];
   localparam logic [NSRC-1:0] MASK_RST = MASK_INIT[NSRC-1:0];

   localparam logic [1:0] SEL_MASK   = 2'd0;
   localparam logic [1:0] SEL_STATUS = 2'd1;
   localparam logic [1:0] SEL_AIACK  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_ACKED   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NSRC-1:0]   mask_q, mask_d;
   logic [NSRC-1:0]   status_q, status_d;
   logic              busy_q, busy_d;
   logic [3:0]        irl_q, irl_d;
   logic [7:0]        vec_q, vec_d;
   logic [IW-1:0]     idx_q, idx_d;

   logic [NSRC-1:0]   cand;
   logic [NSRC-1:0]   ack_clr;
   logic [3:0]        win_lvl;
   logic [IW-1:0]     win_idx;
   logic              win_vld;
   logic [7:0]        win_vec;
   logic              wr_mask, wr_status, wr_aiack;
   logic              iack_take;
   logic [31:0]       rd_data;

   // Register-port strobes; nothing is accepted while CE is low.
   assign wr_mask   = bus.ce & bus.reg_wr & (bus.reg_sel == SEL_MASK);
   assign wr_status = bus.ce & bus.reg_wr & (bus.reg_sel == SEL_STATUS);
   assign wr_aiack  = bus.ce & bus.reg_wr & (bus.reg_sel == SEL_AIACK);

   // An acknowledge only counts while a request is actually presented.
   assign iack_take = bus.ce & bus.iack & (state_q == ST_PRESENT);

   // External sources drop out of arbitration while the A-bus is busy.
   assign cand = status_q & ~mask_q & ~(EXT_SRC & {NSRC{busy_q}});

   // Highest level wins; strict compare keeps ties on the lowest index and
   // keeps level-0 sources from ever winning.
   always_comb begin
      win_lvl = 4'd0;
      win_idx = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (cand[i] && (LVL_TABLE[4*i +: 4] > win_lvl)) begin
            win_lvl = LVL_TABLE[4*i +: 4];
            win_idx = IW'(i);
         end
      end
   end

   assign win_vld = (win_lvl != 4'd0);
   assign win_vec = VEC_BASE + 8'(win_idx);

   // Status update: register clear and acknowledge clear first, new requests
   // last so a coincident pulse always leaves the bit pending.
   always_comb begin
      ack_clr = '0;
      ack_clr[idx_q] = iack_take;
      status_d = status_q;
      if (wr_status) begin
         status_d = status_d & bus.reg_di[NSRC-1:0];
      end
      status_d = status_d & ~ack_clr;
      if (bus.ce) begin
         status_d = status_d | bus.irq;
      end
   end

   // Mask and busy update; acknowledging an external source outranks an
   // AIACK release in the same cycle.
   always_comb begin
      mask_d = mask_q;
      if (wr_mask) begin
         mask_d = bus.reg_di[NSRC-1:0];
      end
      busy_d = busy_q;
      if (wr_aiack && bus.reg_di[0]) begin
         busy_d = 1'b0;
      end
      if (iack_take && EXT_SRC[idx_q]) begin
         busy_d = 1'b1;
      end
   end

   // Presentation FSM: next state and the registered IRL/VEC/index.
   always_comb begin
      state_d = state_q;
      irl_d   = irl_q;
      vec_d   = vec_q;
      idx_d   = idx_q;
      if (bus.ce) begin
         case (state_q)
            ST_IDLE: begin
               if (win_vld) begin
                  irl_d   = win_lvl;
                  vec_d   = win_vec;
                  idx_d   = win_idx;
                  state_d = ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (iack_take) begin
                  irl_d   = 4'd0;
                  vec_d   = 8'd0;
                  state_d = ST_ACKED;
               end else if (win_vld) begin
                  irl_d   = win_lvl;
                  vec_d   = win_vec;
                  idx_d   = win_idx;
               end else begin
                  irl_d   = 4'd0;
                  vec_d   = 8'd0;
                  state_d = ST_IDLE;
               end
            end
            ST_ACKED: begin
               irl_d   = 4'd0;
               vec_d   = 8'd0;
               state_d = ST_IDLE;
            end
            default: begin
               irl_d   = 4'd0;
               vec_d   = 8'd0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and register file; every d-term already holds its value when CE=0.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         mask_q   <= MASK_RST;
         status_q <= '0;
         busy_q   <= 1'b0;
         irl_q    <= 4'd0;
         vec_q    <= 8'd0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         status_q <= status_d;
         busy_q   <= busy_d;
         irl_q    <= irl_d;
         vec_q    <= vec_d;
         idx_q    <= idx_d;
      end
   end

   // Read mux; bits above NSRC and the reserved address read as zero.
   always_comb begin
      rd_data = '0;
      case (bus.reg_sel)
         SEL_MASK:   rd_data[NSRC-1:0] = mask_q;
         SEL_STATUS: rd_data[NSRC-1:0] = status_q;
         SEL_AIACK:  rd_data[0]        = busy_q;
         default:    rd_data           = '0;
      endcase
   end

   assign bus.reg_do = rd_data;
   assign bus.irl    = irl_q;
   assign bus.vec    = vec_q;

endmodule
